// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types and constants for the SQI SRAM responder
package idli_pkg;

  localparam int unsigned SQI_ADDR_W = 16;

  // Direction the initiator is driving the shared nibble bus.
  typedef enum logic {
    SQI_MODE_OUT = 1'b0,
    SQI_MODE_IN  = 1'b1
  } sqi_mode_t;

  typedef enum logic [7:0] {
    SQI_INSTR_WRITE = 8'h02,
    SQI_INSTR_READ  = 8'h03
  } sqi_instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_ADDR,
    ST_DUMMY,
    ST_RD,
    ST_WR,
    ST_ERR
  } idli_sqi_mem_state_t;

endpackage

// File: rtl/idli_sqi_mem_if.sv
// rtl/idli_sqi_mem_if.sv - SQI bus between the core initiator and the memory responder
interface idli_sqi_mem_if;
  import idli_pkg::*;

  logic       sck;
  logic       cs;
  sqi_mode_t  mode;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       oe;

  modport master (output sck, cs, mode, data_in, input data_out, oe);
  modport slave  (input sck, cs, mode, data_in, output data_out, oe);

endinterface

// File: rtl/idli_sqi_mem_arr.sv
// rtl/idli_sqi_mem_arr.sv - MEM_BYTES x 8 flop storage, one write port, one async read port
module idli_sqi_mem_arr_m #(
  parameter  int unsigned MEM_BYTES = 256,
  localparam int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  // Contents deliberately survive reset.
  logic [7:0] mem_q [MEM_BYTES];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/idli_sqi_mem.sv
// rtl/idli_sqi_mem.sv - SQI SRAM responder: decodes READ/WRITE, address, dummies; serves nibbles
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic           i_mem_gck,
  input  logic           i_core_rst_n,
  idli_sqi_mem_if.slave  sqi,
  output logic           o_mem_err
);

  localparam int unsigned             AW        = $clog2(MEM_BYTES);
  localparam logic [SQI_ADDR_W-1:0]   ADDR_MASK = SQI_ADDR_W'(MEM_BYTES - 1);

  idli_sqi_mem_state_t   state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [SQI_ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]            hi_q, hi_d;
  logic                  rd_q, rd_d;
  logic                  err_q, err_d;
  logic [3:0]            dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  wr_en;
  logic [7:0]            rd_byte;
  logic [SQI_ADDR_W-1:0] addr_inc;
  sqi_instr_t            instr;

  assign addr_inc = (addr_q + 16'd1) & ADDR_MASK;
  assign instr    = sqi_instr_t'({hi_q, sqi.data_in});

  idli_sqi_mem_arr_m #(.MEM_BYTES(MEM_BYTES)) u_arr (
    .i_clk   (i_mem_gck),
    .i_we    (wr_en),
    .i_waddr (addr_q[AW-1:0]),
    .i_wdata ({hi_q, sqi.data_in}),
    .i_raddr (addr_q[AW-1:0]),
    .o_rdata (rd_byte)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    rd_d    = rd_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    if (sqi.cs) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (sqi.sck) begin
      unique case (state_q)
        ST_IDLE: begin
          hi_d    = sqi.data_in;
          state_d = ST_INSTR;
        end
        ST_INSTR: begin
          cnt_d = '0;
          if (instr == SQI_INSTR_READ) begin
            rd_d    = 1'b1;
            state_d = ST_ADDR;
          end else if (instr == SQI_INSTR_WRITE) begin
            rd_d    = 1'b0;
            state_d = ST_ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_ADDR: begin
          addr_d = {addr_q[SQI_ADDR_W-5:0], sqi.data_in};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d   = '0;
            state_d = rd_q ? ST_DUMMY : ST_WR;
          end
        end
        ST_DUMMY: begin
          cnt_d = 2'd1;
          if (cnt_q[0]) begin
            cnt_d   = '0;
            state_d = ST_RD;
          end
        end
        // cnt_q[0] tracks which half of the current byte is in flight.
        ST_RD: begin
          cnt_d = 2'd1;
          if (cnt_q[0]) begin
            cnt_d  = '0;
            addr_d = addr_inc;
          end
        end
        ST_WR: begin
          if (cnt_q[0]) begin
            wr_en  = 1'b1;
            addr_d = addr_inc;
            cnt_d  = '0;
          end else begin
            hi_d  = sqi.data_in;
            cnt_d = 2'd1;
          end
        end
        default: ;
      endcase
      if ((state_q == ST_IDLE || state_q == ST_INSTR || state_q == ST_ADDR ||
           state_q == ST_WR) && sqi.mode != SQI_MODE_OUT) begin
        err_d = 1'b1;
      end
      if (state_q == ST_RD && sqi.mode == SQI_MODE_OUT) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_mem_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      hi_q    <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Read data is launched on the falling edge so the initiator samples it mid-stable.
  always_comb begin
    oe_d   = 1'b0;
    dout_d = '0;
    if (state_q == ST_RD) begin
      oe_d   = 1'b1;
      dout_d = cnt_q[0] ? rd_byte[3:0] : rd_byte[7:4];
    end
  end

  always_ff @(negedge i_mem_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      oe_q   <= oe_d;
      dout_q <= dout_d;
    end
  end

  assign sqi.data_out = dout_q;
  assign sqi.oe       = oe_q;
  assign o_mem_err    = err_q;

endmodule
